// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops words from an upstream FIFO and sends them as UART frames
// (start, LSB-first data, optional parity, 1-2 stop bits) on a registered serial line.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int BW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  initial begin
    assert (CLKS_PER_BIT >= 2 && DATA_BITS >= 5 && DATA_BITS <= 9 &&
            (STOP_BITS == 1 || STOP_BITS == 2) &&
            (PARITY_EN == 0 || PARITY_EN == 1) && (PARITY_ODD == 0 || PARITY_ODD == 1))
      else $fatal(1, "uart_tx_serializer: illegal parameter value");
  end
  logic [2:0] state, state_nx;
  logic [BW-1:0] baud;
  logic [IW-1:0] idx;
  logic stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic par;
  logic bit_end;
  logic tx_nx;
  assign bit_end = baud == BAUD_LAST;
  // Gated by rst_n so the FIFO never sees a pop while reset is held.
  assign fifo_pop = rst_n & (state == IDLE) & tx_en & ~fifo_empty;
  assign busy = state != IDLE;
  assign done = (state == STOP) & bit_end & (stop_idx == STOP_LAST);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = fifo_pop ? START : IDLE;
      START:   state_nx = bit_end ? DATA : START;
      DATA:    state_nx = (bit_end && idx == IDX_LAST) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_nx = bit_end ? STOP : PARITY;
      STOP:    state_nx = done ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  // tx is registered, so it is computed from the state being entered this edge.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = (state == DATA && bit_end) ? shreg[1] : shreg[0];
      PARITY:  tx_nx = par;
      default: tx_nx = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud     <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      idx      <= state == DATA ? (bit_end ? idx + 1'b1 : idx) : '0;
      stop_idx <= state == STOP ? (bit_end ? ~stop_idx : stop_idx) : 1'b0;
      tx       <= tx_nx;
      if (fifo_pop) begin
        shreg <= fifo_data;
        par   <= (^fifo_data) ^ (PARITY_ODD != 0);
      end else if (state == DATA && bit_end) begin
        shreg <= shreg >> 1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: three configurations driven from FIFO models; each cycle the
// line, busy, done and pop are compared with a frame-bit reference model.
module tb_uart_tx_serializer;
  localparam int CLKS[3]  = '{4, 4, 3};
  localparam int PEN[3]   = '{0, 1, 1};
  localparam int PODD[3]  = '{0, 1, 0};
  localparam int STOPS[3] = '{1, 2, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic [2:0] tx_o, busy_o, done_o, pop_o;
  logic [7:0] mem[3][256];
  int head[3] = '{0, 0, 0};
  int tail[3] = '{0, 0, 0};
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS[0]), .DATA_BITS(8), .PARITY_EN(PEN[0]),
    .PARITY_ODD(PODD[0]), .STOP_BITS(STOPS[0])) u0 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(head[0] == tail[0]),
    .fifo_data(mem[0][head[0] % 256]), .fifo_pop(pop_o[0]), .tx(tx_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS[1]), .DATA_BITS(8), .PARITY_EN(PEN[1]),
    .PARITY_ODD(PODD[1]), .STOP_BITS(STOPS[1])) u1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(head[1] == tail[1]),
    .fifo_data(mem[1][head[1] % 256]), .fifo_pop(pop_o[1]), .tx(tx_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS[2]), .DATA_BITS(8), .PARITY_EN(PEN[2]),
    .PARITY_ODD(PODD[2]), .STOP_BITS(STOPS[2])) u2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(head[2] == tail[2]),
    .fifo_data(mem[2][head[2] % 256]), .fifo_pop(pop_o[2]), .tx(tx_o[2]),
    .busy(busy_o[2]), .done(done_o[2]));
  always @(posedge clk)
    for (int i = 0; i < 3; i++) if (pop_o[i]) head[i] <= head[i] + 1;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int frame_len(input int i);
    return (1 + 8 + PEN[i] + STOPS[i]) * CLKS[i];
  endfunction
  // Bit k of the frame: 0 start, 1..8 data LSB first, then parity (if enabled), then stop ones.
  function automatic logic frame_bit(input logic [7:0] w, input int k, input int i);
    if (k == 0) return 1'b0;
    if (k <= 8) return w[k-1];
    if (k == 9 && PEN[i] == 1) return (^w) ^ (PODD[i] != 0);
    return 1'b1;
  endfunction
  logic [7:0] word[3];
  int pos[3];
  bit in_f[3];
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        string tag;
        logic e;
        tag = $sformatf("u%0d_line", i);
        if (!rst_n) begin
          in_f[i] = 1'b0;
          check(tag, {4'b0, tx_o[i], busy_o[i], done_o[i], pop_o[i]}, 8'b1000);
        end else if (in_f[i]) begin
          pos[i]++;
          check(tag, {4'b0, tx_o[i], busy_o[i], done_o[i], pop_o[i]},
                {4'b0, frame_bit(word[i], (pos[i] - 1) / CLKS[i], i), 1'b1,
                 pos[i] == frame_len(i), 1'b0});
          if (pos[i] == frame_len(i)) in_f[i] = 1'b0;
        end else begin
          e = tx_en && (head[i] != tail[i]);
          check(tag, {4'b0, tx_o[i], busy_o[i], done_o[i], pop_o[i]}, {4'b0, 3'b100, e});
          if (e) begin
            in_f[i] = 1'b1;
            pos[i] = 0;
            word[i] = mem[i][head[i] % 256];
          end
        end
      end
    end
  end
  task automatic push(input int i, input logic [7:0] v);
    mem[i][tail[i] % 256] = v;
    tail[i]++;
  endtask
  task automatic push_all(input logic [7:0] v);
    for (int i = 0; i < 3; i++) push(i, v);
  endtask
  task automatic drain(input int budget);
    int c;
    c = 0;
    while (c < budget && !(busy_o == 3'b0 && head[0] == tail[0] && head[1] == tail[1] &&
                           head[2] == tail[2])) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_timeout", {7'b0, c < budget}, 8'd1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_all(8'hA5);
    tx_en = 1'b1;
    drain(200);
    push_all(8'h00);
    push_all(8'hFF);
    push_all(8'h3C);
    drain(400);
    push_all(8'h5A);
    push_all(8'h81);
    push_all(8'h7E);
    repeat (10) @(posedge clk);
    #1 tx_en = 1'b0;
    repeat (150) @(posedge clk);
    #1 tx_en = 1'b1;
    drain(400);
    push_all(8'hC3);
    push_all(8'h96);
    @(posedge clk);
    repeat (17) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {2'b0, tx_o, busy_o}, {2'b0, 3'b111, 3'b000});
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain(200);
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 29) == 0 && tail[i] - head[i] < 6) push(i, 8'($urandom));
      if ($urandom_range(0, 79) == 0) tx_en = ~tx_en;
    end
    tx_en = 1'b1;
    drain(1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
